// File: rtl/gpu_layer_pkg.sv
// Shared definitions for the layer header store consumers.
package gpu_layer_pkg;

    localparam int unsigned HEADER_W = 128;
    localparam int unsigned FIELD_W  = 16;
    localparam int unsigned BASE_W   = 32;

    // Header register indices; register k occupies bits [16k+15:16k].
    localparam int unsigned REG_FLAGS   = 0;
    localparam int unsigned REG_X       = 1;
    localparam int unsigned REG_Y       = 2;
    localparam int unsigned REG_WIDTH   = 3;
    localparam int unsigned REG_HEIGHT  = 4;
    localparam int unsigned REG_BASE_LO = 5;
    localparam int unsigned REG_BASE_HI = 6;
    localparam int unsigned REG_COUNT   = 7;

    localparam int unsigned FLAG_ENABLE = 0;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_CHECK = 3'd2,
        S_OUT   = 3'd3,
        S_DONE  = 3'd4
    } scan_state_t;

endpackage

// File: rtl/layer_header_decode.sv
// Splits a layer header into fields and decides whether the layer covers a line.
module layer_header_decode
    import gpu_layer_pkg::*;
#(
    parameter int unsigned COORD_W = 16
) (
    input  logic [HEADER_W-1:0] header,
    input  logic [COORD_W-1:0]  line,
    output logic [FIELD_W-1:0]  flags,
    output logic [COORD_W-1:0]  x,
    output logic [COORD_W-1:0]  width,
    output logic [COORD_W-1:0]  row,
    output logic [BASE_W-1:0]   base,
    output logic                hit
);

    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] height;
    logic [COORD_W:0]   diff;
    logic               enable;
    logic               unused_reg7;

    // Register 7 carries nothing for the scanner.
    assign unused_reg7 = ^header[HEADER_W-1:REG_COUNT*FIELD_W];

    // Field split plus the hit test, done one bit wider so a line above Y cannot wrap.
    always_comb begin
        flags  = header[REG_FLAGS*FIELD_W +: FIELD_W];
        x      = COORD_W'(header[REG_X*FIELD_W +: FIELD_W]);
        y      = COORD_W'(header[REG_Y*FIELD_W +: FIELD_W]);
        width  = COORD_W'(header[REG_WIDTH*FIELD_W +: FIELD_W]);
        height = COORD_W'(header[REG_HEIGHT*FIELD_W +: FIELD_W]);
        base   = {header[REG_BASE_HI*FIELD_W +: FIELD_W], header[REG_BASE_LO*FIELD_W +: FIELD_W]};
        enable = flags[FLAG_ENABLE];
        diff   = {1'b0, line} - {1'b0, y};
        row    = diff[COORD_W-1:0];
        hit    = enable && (width != '0) && (height != '0) && !diff[COORD_W] && (row < height);
    end

endmodule

// File: rtl/layer_line_scanner.sv
// Walks all layer headers on each scanline and emits a descriptor per covering layer.
module layer_line_scanner
    import gpu_layer_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 32,
    parameter int unsigned LAYER_W    = 5,
    parameter int unsigned COORD_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                line_start,
    input  logic [COORD_W-1:0]  line_y,
    output logic [LAYER_W-1:0]  read_layer_pipe,
    input  logic [HEADER_W-1:0] layer_info,
    output logic                desc_valid,
    input  logic                desc_ready,
    output logic [LAYER_W-1:0]  desc_layer,
    output logic [COORD_W-1:0]  desc_x,
    output logic [COORD_W-1:0]  desc_width,
    output logic [COORD_W-1:0]  desc_row,
    output logic [BASE_W-1:0]   desc_base,
    output logic [FIELD_W-1:0]  desc_flags,
    output logic                scan_busy,
    output logic                line_done,
    output logic                line_overrun
);

    localparam logic [LAYER_W-1:0] LAST_IDX = LAYER_W'(NUM_LAYERS - 1);

    scan_state_t        state;
    scan_state_t        state_next;
    logic [COORD_W-1:0] line_q;

    logic [FIELD_W-1:0] dec_flags;
    logic [COORD_W-1:0] dec_x;
    logic [COORD_W-1:0] dec_width;
    logic [COORD_W-1:0] dec_row;
    logic [BASE_W-1:0]  dec_base;
    logic               dec_hit;

    logic               last;
    logic               abort;
    logic               load_line;
    logic               load_desc;
    logic               idx_inc;

    assign last = (read_layer_pipe == LAST_IDX);

    layer_header_decode #(
        .COORD_W (COORD_W)
    ) u_decode (
        .header (layer_info),
        .line   (line_q),
        .flags  (dec_flags),
        .x      (dec_x),
        .width  (dec_width),
        .row    (dec_row),
        .base   (dec_base),
        .hit    (dec_hit)
    );

    // State register with the status flags registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            desc_valid   <= 1'b0;
            scan_busy    <= 1'b0;
            line_done    <= 1'b0;
            line_overrun <= 1'b0;
        end else begin
            state        <= state_next;
            desc_valid   <= (state_next == S_OUT);
            scan_busy    <= (state_next != S_IDLE);
            line_done    <= (state_next == S_DONE);
            line_overrun <= abort;
        end
    end

    // Next-state logic; a new line during an active scan always restarts at ADDR.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (line_start) state_next = S_ADDR;
            S_ADDR:  state_next = S_CHECK;
            S_CHECK: begin
                if (dec_hit)   state_next = S_OUT;
                else if (last) state_next = S_DONE;
                else           state_next = S_ADDR;
            end
            S_OUT:   if (desc_ready) state_next = last ? S_DONE : S_ADDR;
            S_DONE:  state_next = line_start ? S_ADDR : S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort) state_next = S_ADDR;
    end

    // Datapath controls decoded from the current state.
    always_comb begin
        abort     = 1'b0;
        load_line = 1'b0;
        load_desc = 1'b0;
        idx_inc   = 1'b0;
        case (state)
            S_IDLE, S_DONE: load_line = line_start;
            S_ADDR:  abort = line_start;
            S_CHECK: begin
                abort     = line_start;
                load_desc = dec_hit && !line_start;
                idx_inc   = !dec_hit && !last && !line_start;
            end
            S_OUT: begin
                abort   = line_start;
                idx_inc = desc_ready && !last && !line_start;
            end
            default: ;
        endcase
        if (abort) load_line = 1'b1;
    end

    // Line latch, layer index and descriptor registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            line_q          <= '0;
            read_layer_pipe <= '0;
            desc_layer      <= '0;
            desc_x          <= '0;
            desc_width      <= '0;
            desc_row        <= '0;
            desc_base       <= '0;
            desc_flags      <= '0;
        end else begin
            if (load_line) begin
                line_q          <= line_y;
                read_layer_pipe <= '0;
            end else if (idx_inc) begin
                read_layer_pipe <= read_layer_pipe + LAYER_W'(1);
            end
            if (load_desc) begin
                desc_layer <= read_layer_pipe;
                desc_x     <= dec_x;
                desc_width <= dec_width;
                desc_row   <= dec_row;
                desc_base  <= dec_base;
                desc_flags <= dec_flags;
            end
        end
    end

endmodule

// File: tb/tb_layer_line_scanner.sv
// Directed bench for layer_line_scanner with a one-cycle-latency header store model.
module tb_layer_line_scanner;

    logic         clk;
    logic         reset;
    logic         line_start;
    logic [15:0]  line_y;
    logic [4:0]   read_layer_pipe;
    logic [127:0] layer_info;
    logic         desc_valid;
    logic         desc_ready;
    logic [4:0]   desc_layer;
    logic [15:0]  desc_x;
    logic [15:0]  desc_width;
    logic [15:0]  desc_row;
    logic [31:0]  desc_base;
    logic [15:0]  desc_flags;
    logic         scan_busy;
    logic         line_done;
    logic         line_overrun;

    logic [127:0] hdr_mem [32];

    int checks   = 0;
    int failures = 0;

    int          n_desc;
    int          valid_cycles;
    int          busy_low;
    int          overruns;
    int          done_cyc;
    int          stall_seen;
    int          stall_bad;
    int          stall_layer = -1;
    int          stall_len   = 0;
    logic [4:0]  d_layer [8];
    logic [15:0] d_x     [8];
    logic [15:0] d_w     [8];
    logic [15:0] d_row   [8];
    logic [15:0] d_flags [8];
    logic [31:0] d_base  [8];
    int          d_cyc   [8];

    layer_line_scanner dut (
        .clk             (clk),
        .reset           (reset),
        .line_start      (line_start),
        .line_y          (line_y),
        .read_layer_pipe (read_layer_pipe),
        .layer_info      (layer_info),
        .desc_valid      (desc_valid),
        .desc_ready      (desc_ready),
        .desc_layer      (desc_layer),
        .desc_x          (desc_x),
        .desc_width      (desc_width),
        .desc_row        (desc_row),
        .desc_base       (desc_base),
        .desc_flags      (desc_flags),
        .scan_busy       (scan_busy),
        .line_done       (line_done),
        .line_overrun    (line_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Header store: data for the presented index appears one cycle later.
    always @(posedge clk) layer_info <= hdr_mem[read_layer_pipe];

    function automatic logic [127:0] make_hdr(input logic [15:0] flags, input logic [15:0] x,
                                              input logic [15:0] y, input logic [15:0] w,
                                              input logic [15:0] h, input logic [31:0] base);
        return {16'hDEAD, base[31:16], base[15:0], h, w, y, x, flags};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_hdrs();
        for (int i = 0; i < 32; i++) hdr_mem[i] = '0;
    endtask

    task automatic start_line(input logic [15:0] y);
        line_start = 1'b1;
        line_y     = y;
        tick();
        line_start = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rlp"},     64'(read_layer_pipe), 64'd0);
        check({tag, "_valid"},   64'(desc_valid),      64'd0);
        check({tag, "_layer"},   64'(desc_layer),      64'd0);
        check({tag, "_x"},       64'(desc_x),          64'd0);
        check({tag, "_width"},   64'(desc_width),      64'd0);
        check({tag, "_row"},     64'(desc_row),        64'd0);
        check({tag, "_base"},    64'(desc_base),       64'd0);
        check({tag, "_flags"},   64'(desc_flags),      64'd0);
        check({tag, "_busy"},    64'(scan_busy),       64'd0);
        check({tag, "_done"},    64'(line_done),       64'd0);
        check({tag, "_overrun"}, 64'(line_overrun),    64'd0);
    endtask

    // Runs from cycle 1 of a line until line_done, accepting and recording descriptors.
    task automatic collect_line(input int budget);
        int          cyc;
        int          scnt;
        logic [92:0] snap;
        n_desc = 0; valid_cycles = 0; busy_low = 0; overruns = 0;
        stall_seen = 0; stall_bad = 0; done_cyc = -1;
        cyc = 1; scnt = 0; snap = '0;
        while (cyc <= budget && done_cyc < 0) begin
            if (!scan_busy) busy_low++;
            if (line_overrun) overruns++;
            if (line_done) done_cyc = cyc;
            desc_ready = 1'b1;
            if (desc_valid) begin
                valid_cycles++;
                if (int'(desc_layer) == stall_layer && scnt < stall_len) begin
                    if (scnt == 0)
                        snap = {desc_layer, desc_x, desc_width, desc_row, desc_base, read_layer_pipe};
                    else if (snap != {desc_layer, desc_x, desc_width, desc_row, desc_base, read_layer_pipe})
                        stall_bad++;
                    scnt++;
                    stall_seen++;
                    desc_ready = 1'b0;
                end else begin
                    if (n_desc < 8) begin
                        d_layer[n_desc] = desc_layer;
                        d_x[n_desc]     = desc_x;
                        d_w[n_desc]     = desc_width;
                        d_row[n_desc]   = desc_row;
                        d_base[n_desc]  = desc_base;
                        d_flags[n_desc] = desc_flags;
                        d_cyc[n_desc]   = cyc;
                    end
                    n_desc++;
                end
            end
            tick();
            cyc++;
        end
        desc_ready = 1'b1;
    endtask

    initial begin
        int w;
        reset      = 1'b0;
        line_start = 1'b0;
        line_y     = '0;
        desc_ready = 1'b1;
        clear_hdrs();
        #2;
        check_all_zero("reset");
        tick(); tick();
        reset = 1'b1;
        tick();

        // All headers zero: no descriptors, done 65 cycles after the pulse.
        start_line(16'd10);
        check("zero_rlp_c1", 64'(read_layer_pipe), 64'd0);
        check("zero_busy_c1", 64'(scan_busy), 64'd1);
        collect_line(200);
        check("zero_done_cyc", 64'(done_cyc), 64'd65);
        check("zero_ndesc", 64'(n_desc), 64'd0);
        check("zero_valid_cycles", 64'(valid_cycles), 64'd0);
        check("zero_busy_low", 64'(busy_low), 64'd0);
        check("zero_overruns", 64'(overruns), 64'd0);
        check("zero_done_pulse", 64'(line_done), 64'd0);
        check("zero_busy_after", 64'(scan_busy), 64'd0);
        check("zero_rlp_hold", 64'(read_layer_pipe), 64'd31);

        // Single layer 3 covering lines 100..115.
        hdr_mem[3] = make_hdr(16'h0001, 16'd40, 16'd100, 16'd64, 16'd16, 32'h0001_2000);
        start_line(16'd99);
        collect_line(200);
        check("l99_ndesc", 64'(n_desc), 64'd0);
        check("l99_done", 64'(done_cyc), 64'd65);
        start_line(16'd100);
        collect_line(200);
        check("l100_ndesc", 64'(n_desc), 64'd1);
        check("l100_layer", 64'(d_layer[0]), 64'd3);
        check("l100_row", 64'(d_row[0]), 64'd0);
        check("l100_base", 64'(d_base[0]), 64'h0001_2000);
        check("l100_x", 64'(d_x[0]), 64'd40);
        check("l100_width", 64'(d_w[0]), 64'd64);
        check("l100_flags", 64'(d_flags[0]), 64'h0001);
        check("l100_valid_cyc", 64'(d_cyc[0]), 64'd9);
        check("l100_done", 64'(done_cyc), 64'd66);
        start_line(16'd115);
        collect_line(200);
        check("l115_ndesc", 64'(n_desc), 64'd1);
        check("l115_layer", 64'(d_layer[0]), 64'd3);
        check("l115_row", 64'(d_row[0]), 64'd15);
        check("l115_base", 64'(d_base[0]), 64'h0001_2000);
        start_line(16'd116);
        collect_line(200);
        check("l116_ndesc", 64'(n_desc), 64'd0);

        // Layers 2, 7 and 31 cover line 5; ready held high.
        clear_hdrs();
        hdr_mem[2]  = make_hdr(16'h0001, 16'd1,  16'd0, 16'd10, 16'd10, 32'h1000_0000);
        hdr_mem[7]  = make_hdr(16'h0081, 16'd7,  16'd5, 16'd3,  16'd1,  32'h2000_0000);
        hdr_mem[31] = make_hdr(16'h0001, 16'd31, 16'd4, 16'd2,  16'd2,  32'h3000_0000);
        start_line(16'd5);
        collect_line(200);
        check("three_ndesc", 64'(n_desc), 64'd3);
        check("three_order0", 64'(d_layer[0]), 64'd2);
        check("three_order1", 64'(d_layer[1]), 64'd7);
        check("three_order2", 64'(d_layer[2]), 64'd31);
        check("three_rows", {16'(d_row[0]), 16'(d_row[1]), 16'(d_row[2])}, {16'd5, 16'd0, 16'd1});
        check("three_cycles", {16'(d_cyc[0]), 16'(d_cyc[1]), 16'(d_cyc[2])}, {16'd7, 16'd18, 16'd67});
        check("three_valid_cycles", 64'(valid_cycles), 64'd3);
        check("three_done", 64'(done_cyc), 64'd68);

        // Same line with a 20-cycle stall on layer 7.
        stall_layer = 7;
        stall_len   = 20;
        start_line(16'd5);
        collect_line(300);
        stall_layer = -1;
        stall_len   = 0;
        check("stall_seen", 64'(stall_seen), 64'd20);
        check("stall_stable", 64'(stall_bad), 64'd0);
        check("stall_ndesc", 64'(n_desc), 64'd3);
        check("stall_order", {16'(d_layer[0]), 16'(d_layer[1]), 16'(d_layer[2])}, {16'd2, 16'd7, 16'd31});
        check("stall_l7_flags", 64'(d_flags[1]), 64'h0081);
        check("stall_l31_cyc", 64'(d_cyc[2]), 64'd87);
        check("stall_valid_cycles", 64'(valid_cycles), 64'd23);
        check("stall_done", 64'(done_cyc), 64'd88);

        // Restart mid-scan at layer 12 with line 6.
        start_line(16'd5);
        w = 0;
        while (read_layer_pipe != 5'd12 && w < 100) begin
            check("ovr_no_done", 64'(line_done), 64'd0);
            tick();
            w++;
        end
        check("ovr_reach12", 64'(read_layer_pipe), 64'd12);
        line_start = 1'b1;
        line_y     = 16'd6;
        tick();
        line_start = 1'b0;
        check("ovr_pulse", 64'(line_overrun), 64'd1);
        check("ovr_rlp0", 64'(read_layer_pipe), 64'd0);
        check("ovr_busy", 64'(scan_busy), 64'd1);
        check("ovr_valid", 64'(desc_valid), 64'd0);
        collect_line(200);
        check("ovr_overruns", 64'(overruns), 64'd1);
        check("ovr_ndesc", 64'(n_desc), 64'd1);
        check("ovr_layer", 64'(d_layer[0]), 64'd2);
        check("ovr_row", 64'(d_row[0]), 64'd6);
        check("ovr_done", 64'(done_cyc), 64'd66);
        check("ovr_done_single", 64'(line_done), 64'd0);

        // New line arriving in the DONE cycle.
        clear_hdrs();
        start_line(16'd1);
        w = 1;
        while (!line_done && w < 200) begin
            tick();
            w++;
        end
        check("dstart_done_cyc", 64'(w), 64'd65);
        line_start = 1'b1;
        line_y     = 16'd2;
        tick();
        line_start = 1'b0;
        check("dstart_no_overrun", 64'(line_overrun), 64'd0);
        check("dstart_busy", 64'(scan_busy), 64'd1);
        check("dstart_rlp", 64'(read_layer_pipe), 64'd0);
        check("dstart_done_low", 64'(line_done), 64'd0);
        collect_line(200);
        check("dstart_second_done", 64'(done_cyc), 64'd65);
        check("dstart_overruns", 64'(overruns), 64'd0);

        // Y near the top of the coordinate range must not wrap.
        hdr_mem[0] = make_hdr(16'h0001, 16'd0, 16'hFFF0, 16'd1, 16'h0020, 32'h0);
        start_line(16'h0005);
        collect_line(200);
        check("wrap_ndesc", 64'(n_desc), 64'd0);
        start_line(16'hFFFF);
        collect_line(200);
        check("top_ndesc", 64'(n_desc), 64'd1);
        check("top_row", 64'(d_row[0]), 64'h000F);

        // Asynchronous reset while a descriptor is presented.
        hdr_mem[0] = make_hdr(16'h0001, 16'd9, 16'd0, 16'd4, 16'd1, 32'hCAFE_0000);
        desc_ready = 1'b0;
        start_line(16'd0);
        tick(); tick();
        check("arst_valid_before", 64'(desc_valid), 64'd1);
        check("arst_x_before", 64'(desc_x), 64'd9);
        #3;
        reset = 1'b0;
        #1;
        check_all_zero("arst");
        tick();
        reset      = 1'b1;
        desc_ready = 1'b1;
        tick();
        check("arst_idle_busy", 64'(scan_busy), 64'd0);
        check("arst_idle_valid", 64'(desc_valid), 64'd0);
        start_line(16'd0);
        collect_line(200);
        check("arst_rescan_ndesc", 64'(n_desc), 64'd1);
        check("arst_rescan_base", 64'(d_base[0]), 64'hCAFE_0000);
        check("arst_rescan_done", 64'(done_cyc), 64'd66);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
